pipe_skid_stage: RTL and testbench

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_skid_stage.sv | 120 ++++++++++++
 tb/tb_pipe_skid_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: two-entry skid buffer (main + skid register) between a
// valid/ready producer and consumer, with synchronous flush and stall counter.
// Latency: 1 cycle when the stage is empty, or when it holds one entry and drains it that cycle.
// Backpressure: ready_o is registered (0 only when both entries are held), so there
// is no combinational path from ready_i to ready_o.
// Ports:
//   clk, rst (async active-low)  | flush_i: discard all held entries
//   valid_i/ready_o/data_i       : upstream handshake
//   valid_o/ready_i/data_o       : downstream handshake (data_o driven by main)
//   occ_o                        : entries held (0..2)
//   stall_cnt_o                  : saturating count of valid_o & ~ready_i cycles
module pipe_skid_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [1:0]       occ_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   main_q, main_d;
  logic [WIDTH-1:0]   skid_q, skid_d;
  logic               ready_q, ready_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic in_xfer;
  logic out_xfer;

  assign valid_o     = (state_q != EMPTY);
  assign ready_o     = ready_q;
  assign data_o      = main_q;
  assign occ_o       = state_q;
  assign stall_cnt_o = stall_cnt_q;

  assign in_xfer  = valid_i & ready_q;
  assign out_xfer = valid_o & ready_i;

  always_comb begin
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_d  = data_i;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = data_i;
        end else if (in_xfer) begin
          skid_d  = data_i;
          state_d = FULL;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // ready_q is 0 here, so no input can land on top of the skid entry.
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush overrides every transfer. Registers keep their contents so data_o
    // stays put; only the state (and thus valid_o) collapses. An input offered
    // this cycle may have been written into main/skid above, so undo that.
    if (flush_i) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end

    // Counts stalls independently of flush and saturates at all-ones.
    if (valid_o && !ready_i && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // ready_o is a pure function of the next state, registered.
  assign ready_d = (state_d != FULL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      ready_q     <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      ready_q     <= ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Testbench for pipe_skid_stage: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the stage's contents.
module tb_pipe_skid_stage;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             flush_i;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] data_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] data_o;
  logic [1:0]       occ_o;
  logic [CNT_W-1:0] stall_cnt_o;

  pipe_skid_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_i      (data_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .occ_o       (occ_o),
    .stall_cnt_o (stall_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: FIFO of held payloads, last value seen at the head,
  // and the saturating stall count.
  logic [WIDTH-1:0] mdl_q[$];
  logic [WIDTH-1:0] mdl_dout;
  int               mdl_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".valid_o"}, 32'(valid_o), 32'(mdl_q.size() > 0));
    chk({tag, ".ready_o"}, 32'(ready_o), 32'(mdl_q.size() < 2));
    chk({tag, ".occ_o"},   32'(occ_o),   32'(mdl_q.size()));
    chk({tag, ".data_o"},  data_o,       mdl_dout);
    chk({tag, ".stall"},   32'(stall_cnt_o), 32'(mdl_stall));
  endtask

  // Called at a negedge: check outputs, drive inputs, advance the model,
  // then move to the next negedge.
  task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic r,
                      input logic f, input string tag);
    logic acc;
    logic dlv;
    chk_model(tag);
    valid_i = v;
    data_i  = d;
    ready_i = r;
    flush_i = f;
    acc = v && (mdl_q.size() < 2);
    dlv = r && (mdl_q.size() > 0);
    if (mdl_q.size() > 0 && !r && mdl_stall < CNT_MAX) mdl_stall++;
    if (f) begin
      mdl_q.delete();
    end else begin
      if (dlv) void'(mdl_q.pop_front());
      if (acc) mdl_q.push_back(d);
    end
    if (mdl_q.size() > 0) mdl_dout = mdl_q[0];
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    valid_i = 1'b0;
    flush_i = 1'b0;
    ready_i = 1'b0;
    data_i  = '0;
    mdl_q.delete();
    mdl_dout  = '0;
    mdl_stall = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    logic [WIDTH-1:0] held;
    logic             stalled;

    do_reset();
    chk("rst.valid_o", 32'(valid_o), 32'd0);
    chk("rst.ready_o", 32'(ready_o), 32'd1);
    chk("rst.occ_o",   32'(occ_o),   32'd0);
    chk("rst.data_o",  data_o,       32'd0);
    chk("rst.stall",   32'(stall_cnt_o), 32'd0);

    // Streaming 0x1..0x8, each visible one cycle after acceptance.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, WIDTH'(i), 1'b1, 1'b0, "stream");
      chk("stream.data", data_o, 32'(i));
      chk("stream.occ",  32'(occ_o), 32'd1);
    end
    step(1'b0, '0, 1'b1, 1'b0, "stream_drain");
    chk("stream.stall", 32'(stall_cnt_o), 32'd0);
    chk("stream.empty", 32'(valid_o), 32'd0);

    // Backpressure: A held, offer B while stalled.
    do_reset();
    step(1'b1, 32'hA, 1'b0, 1'b0, "bp_fill");
    chk("bp.one_data", data_o, 32'hA);
    step(1'b1, 32'hB, 1'b0, 1'b0, "bp_offer");
    chk("bp.occ2",   32'(occ_o),   32'd2);
    chk("bp.rdy0",   32'(ready_o), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0, "bp_hold");
    chk("bp.out_a",  data_o, 32'hA);
    step(1'b0, '0, 1'b1, 1'b0, "bp_drain_a");
    chk("bp.out_b",  data_o, 32'hB);
    chk("bp.valid_b", 32'(valid_o), 32'd1);
    step(1'b0, '0, 1'b1, 1'b0, "bp_drain_b");
    chk("bp.empty",  32'(valid_o), 32'd0);
    chk("bp.stall",  32'(stall_cnt_o), 32'd2);

    // Flush while FULL with a new input offered.
    do_reset();
    step(1'b1, 32'hA, 1'b0, 1'b0, "fl_a");
    step(1'b1, 32'hB, 1'b0, 1'b0, "fl_b");
    chk("fl.full", 32'(occ_o), 32'd2);
    step(1'b1, 32'hC, 1'b0, 1'b1, "fl_flush");
    chk("fl.valid", 32'(valid_o), 32'd0);
    chk("fl.occ",   32'(occ_o),   32'd0);
    chk("fl.ready", 32'(ready_o), 32'd1);
    chk("fl.data_kept", data_o,   32'hA);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, "fl_after");
      chk("fl.no_emit", 32'(valid_o), 32'd0);
    end

    // Stall counter saturation at 2^4-1.
    do_reset();
    step(1'b1, 32'h77, 1'b0, 1'b0, "sat_fill");
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b0, "sat");
    chk("sat.stall", 32'(stall_cnt_o), 32'd15);

    // Asynchronous reset between edges while FULL.
    do_reset();
    step(1'b1, 32'h11, 1'b0, 1'b0, "ar_a");
    step(1'b1, 32'h22, 1'b0, 1'b0, "ar_b");
    chk("ar.full", 32'(occ_o), 32'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("ar.valid", 32'(valid_o), 32'd0);
    chk("ar.occ",   32'(occ_o),   32'd0);
    chk("ar.data",  data_o,       32'd0);
    chk("ar.ready", 32'(ready_o), 32'd1);
    mdl_q.delete();
    mdl_dout  = '0;
    mdl_stall = 0;
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 32'h55, 1'b1, 1'b0, "ar_first");
    chk("ar.first_valid", 32'(valid_o), 32'd1);
    chk("ar.first_data",  data_o,       32'h55);

    // Randomized traffic against the reference model.
    do_reset();
    stalled = 1'b0;
    held    = '0;
    for (int i = 0; i < 10000; i++) begin
      logic             v, r, f;
      logic [WIDTH-1:0] d;
      v = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 24) == 0);
      d = $urandom;
      if (stalled) chk("rnd.stable", data_o, held);
      stalled = valid_o && !r && !f;
      held    = data_o;
      step(v, d, r, f, "rnd");
    end
    chk_model("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
